div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider for DIV/DIVU in the EX stage, beside the ALU. It computes quotient and remainder with a radix-2 restoring algorithm, one bit per cycle, and returns a 64-bit {remainder, quotient} word for the HI/LO path. That is the same packing the ALU uses for its 64-bit multiply result. While a division is in flight it holds a stall request so the pipeline freezes EX until the result is ready.

## Interface
Parameters:
- WIDTH, 32, operand width. Only 32 is supported.

Ports:
- clk_i  in  1  clock. All state changes on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  request a division. Sampled only in IDLE.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start_i.
- annul_i  in  1  abort the current operation, for example on an exception or flush in a later stage.
- dividend_i  in  32  dividend. Sampled with start_i.
- divisor_i  in  32  divisor. Sampled with start_i.
- result_o  out  64  {remainder[31:0], quotient[31:0]}, giving HI = remainder and LO = quotient.
- ready_o  out  1  result_o is valid this cycle. Single-cycle pulse.
- busy_o  out  1  stall request to the pipeline control.

## Operation
States:
- **IDLE**
  - If start_i=1, annul_i=0 and divisor_i=0, go to DZERO.
  - If start_i=1, annul_i=0 and divisor_i≠0, go to RUN.
  - While in IDLE, operands are latched on any start_i=1 edge.
- **DZERO**: go to DONE with result forced to 64'h0.
- **RUN**: 32 iterations, counted by a 6-bit counter that cleared on entry. After the 32nd iteration, go to DONE.
- **DONE**: ready_o=1. Next state is IDLE unconditionally.

annul_i=1 in any state makes the next state IDLE. ready_o is not asserted and result_o is left unchanged.

Operand preparation on accept:
- If signed_i=1, latch the magnitudes |dividend| and |divisor|, computed as the two's-complement negate when bit 31 is set.
- Latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31].
- If signed_i=0, latch the raw values and force both signs to 0.

RUN iteration, on a 64-bit working register {rem, quo}, with quo initialised to the dividend magnitude and rem to 0:
- Form trial = {rem[30:0], quo[31]} as 33-bit, minus {1'b0, divisor}.
- If trial[32]=0 (no borrow): rem ← trial[31:0], quo ← {quo[30:0], 1'b1}.
- Otherwise: rem ← {rem[30:0], quo[31]}, quo ← {quo[30:0], 1'b0}.

Sign fix, applied on the transition into DONE:
- quotient = sign_q ? −quo : quo
- remainder = sign_r ? −rem : rem
- Both are computed modulo 2^32.

Overflow case: signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0. No exception is raised.

Divide by zero yields result_o = 64'h0. This is a decided value, not UNPREDICTABLE.

Output behaviour:
- result_o is registered. It updates only on entry to DONE, and holds its value until the next DONE.
- busy_o = 1 in DZERO and RUN, and also in the IDLE cycle in which start_i is accepted (combinational from start_i, so EX stalls in the same cycle).
- busy_o = 0 in DONE, so the pipeline advances and consumes the result that cycle.
- start_i outside IDLE is ignored. The pipeline must present the instruction again after DONE if needed.
- annul_i and start_i high together in IDLE: annul_i wins, nothing is accepted, and busy_o=0.

## Timing
- Reset (rst_n_i=0, asynchronous): state=IDLE, counter=0, result_o=64'h0, ready_o=0, busy_o=0. The working registers clear to 0.
- Reset during RUN aborts immediately with no ready_o. Operation resumes normally after rst_n_i deasserts.
- Cycle numbering: start accepted at edge 0.
- Nonzero divisor: RUN occupies cycles 1..32. DONE (ready_o=1, result_o valid) is cycle 33. IDLE is cycle 34, and a new start is accepted there at the earliest.
- Zero divisor: DZERO is cycle 1 and DONE is cycle 2.
- Latency is fixed regardless of operand values. There is no early termination.
- annul_i takes effect at the next edge. busy_o falls in the cycle after annul_i is sampled.

## Test plan
- **Unsigned:** DIVU 100 / 7.
  - result_o = {32'd2, 32'd14}, with ready_o high exactly at cycle 33.
  - busy_o is high for cycles 0..32 and low at cycle 33.
- **Signed:** DIV −7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - Also check 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- **Edge values:**
  - DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
  - DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- **Divide by zero:** DIVU 5 / 0 → ready_o at cycle 2, result_o = 64'h0.
- **Annul:**
  - Assert annul_i at cycle 10 of a run → no ready_o, IDLE at cycle 11, result_o keeps its previous value.
  - An immediate new start then completes correctly.
- **Reset and ignored start:**
  - Drive start_i with different operands during RUN → ignored, and the original result is returned.
  - Assert rst_n_i low at cycle 20 → all outputs are 0 asynchronously.

Source files
------------

// File: rtl/div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle 32-bit DIV/DIVU unit for the EX stage. Radix-2
//               restoring division, one quotient bit per cycle, returning
//               {remainder, quotient} for the HI/LO path. Holds a stall
//               request while a division is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic                 annul_i,
    input  logic [WIDTH-1:0]     dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DZERO = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Index of the final RUN iteration (32 iterations: 0..31)
    localparam logic [5:0] LAST_ITER = 6'd31;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]           state;
    logic [5:0]           count;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     dvsr;
    logic                 sign_q;
    logic                 sign_r;
    logic [2*WIDTH-1:0]   result;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic [1:0]           state_nx;
    logic                 accept;
    logic                 last_iter;
    logic                 dvsr_zero;
    logic [WIDTH-1:0]     dividend_mag;
    logic [WIDTH-1:0]     divisor_mag;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH-1:0]     quo_nx;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Start acceptance: only in IDLE, and annul always takes priority
    always_comb begin
        accept    = (state == S_IDLE) && start_i && !annul_i;
        last_iter = (state == S_RUN) && (count == LAST_ITER);
        dvsr_zero = (divisor_i == '0);
    end

    // Operand magnitudes; the most negative value maps onto itself, which is
    // exactly the unsigned magnitude 2^31 the iteration needs
    always_comb begin
        dividend_mag = (signed_i && dividend_i[WIDTH-1]) ? (~dividend_i + 1'b1) : dividend_i;
        divisor_mag  = (signed_i && divisor_i[WIDTH-1])  ? (~divisor_i  + 1'b1) : divisor_i;
    end

    // One restoring step: shift in the next dividend bit and try to subtract.
    // The partial remainder stays below 2^k after k steps, so the bit shifted
    // out of rem[WIDTH-1] is always zero.
    always_comb begin
        trial = {1'b0, rem[WIDTH-2:0], quo[WIDTH-1]} - {1'b0, dvsr};
        if (!trial[WIDTH]) begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // Sign restoration of the final step's outputs (modulo 2^WIDTH)
    always_comb begin
        quo_fix = sign_q ? (~quo_nx + 1'b1) : quo_nx;
        rem_fix = sign_r ? (~rem_nx + 1'b1) : rem_nx;
    end

    // Next-state logic; annul returns to IDLE from any state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = dvsr_zero ? S_DZERO : S_RUN;
                end
            end
            S_DZERO: begin
                state_nx = S_DONE;
            end
            S_RUN: begin
                if (count == LAST_ITER) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (annul_i) begin
            state_nx = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Iteration counter: cleared when a division is accepted, counts RUN cycles
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
        end else if (state == S_RUN) begin
            count <= count + 6'd1;
        end
    end

    // Operand capture in IDLE and the per-cycle restoring step during RUN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else if ((state == S_IDLE) && start_i) begin
            rem    <= '0;
            quo    <= dividend_mag;
            dvsr   <= divisor_mag;
            sign_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            sign_r <= signed_i & dividend_i[WIDTH-1];
        end else if (state == S_RUN) begin
            rem    <= rem_nx;
            quo    <= quo_nx;
        end
    end

    // Result register: written only on a real transition into DONE, so an
    // annulled operation leaves the previous result visible
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result <= '0;
        end else if (!annul_i) begin
            if (state == S_DZERO) begin
                result <= '0;
            end else if (last_iter) begin
                result <= {rem_fix, quo_fix};
            end
        end
    end

    // Outputs: the stall request covers the accepting IDLE cycle combinationally
    // and drops in DONE so EX consumes the result in that cycle
    always_comb begin
        result_o = result;
        ready_o  = (state == S_DONE);
        busy_o   = rst_n_i && (accept || (state == S_DZERO) || (state == S_RUN));
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit: table of directed divisions
//               plus hand sequences for annul, ignored start and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic        annul;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    div_unit #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .signed_i   (sgn),
        .annul_i    (annul),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .result_o   (result),
        .ready_o    (ready),
        .busy_o     (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one division at the current cycle (cycle 0) and wait for ready.
    // Returns the ready cycle (-1 on timeout), the result seen with ready, and
    // a count of cycles where busy disagreed with "high until ready".
    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res, output int busy_bad);
        lat      = -1;
        res      = '0;
        busy_bad = 0;
        sgn      = sg;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                res = result;
                if (busy) busy_bad++;
            end else if (!busy) begin
                busy_bad++;
            end
            tick();
            start = 1'b0;
        end
    endtask

    // Run one division and check latency, value, busy profile and result hold
    task automatic run_check(input string name, input logic sg, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int          lat;
        logic [63:0] res;
        int          bb;
        do_div(sg, a, b, lat, res, bb);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, res, exp);
        chk({name, " busy profile"}, 64'(bb), 64'd0);
        // first IDLE cycle after DONE: pulse gone, result held
        chk({name, " ready pulse"}, {63'd0, ready}, 64'd0);
        chk({name, " result hold"}, result, exp);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD},    33};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000},           33};
        vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0, 32'hFFFFFFFF},           33};
        vecs[5] = '{1'b0, 32'd5,          32'd0,          64'h0,                           2};
        vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE, 32'hFFFFFFF2},    33};
        vecs[7] = '{1'b1, 32'd5,          32'd0,          64'h0,                           2};
        vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'h0, 32'h1},                  33};
        vecs[9] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0},           33};

        rst_n    = 1'b0;
        start    = 1'b0;
        sgn      = 1'b0;
        annul    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        tick();
        tick();
        chk("reset result", result, 64'h0);
        chk("reset ready", {63'd0, ready}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors, back to back at the earliest restart cycle
        for (int i = 0; i < 10; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b,
                      vecs[i].exp, vecs[i].lat);
        end

        // start with annul in IDLE: not accepted, no stall
        start = 1'b1;
        annul = 1'b1;
        sgn = 1'b0;
        dividend = 32'd9;
        divisor = 32'd3;
        #1;
        chk("annul+start busy", {63'd0, busy}, 64'd0);
        tick();
        start = 1'b0;
        annul = 1'b0;
        #1;
        chk("annul+start no run", {63'd0, busy}, 64'd0);
        tick();

        // Annul at cycle 10 of a run
        begin
            int ready_seen = 0;
            sgn = 1'b0;
            dividend = 32'd1000;
            divisor = 32'd3;
            start = 1'b1;
            for (int c = 0; c <= 10; c++) begin
                if (c == 10) annul = 1'b1;
                @(negedge clk);
                if (ready) ready_seen++;
                if (c == 10) chk("annul cycle busy", {63'd0, busy}, 64'd1);
                tick();
                start = 1'b0;
            end
            annul = 1'b0;
            #1;
            chk("annul no ready", 64'(ready_seen), 64'd0);
            chk("annul idle busy", {63'd0, busy}, 64'd0);
            chk("annul idle ready", {63'd0, ready}, 64'd0);
            chk("annul result kept", result, {32'h80000000, 32'h0});
        end
        run_check("after annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

        // Start pulses with other operands during RUN are ignored
        begin
            int          lat = -1;
            logic [63:0] res = '0;
            sgn = 1'b0;
            dividend = 32'd100;
            divisor = 32'd7;
            start = 1'b1;
            for (int c = 0; c < 60 && lat < 0; c++) begin
                @(negedge clk);
                if (ready) begin
                    lat = c;
                    res = result;
                end
                tick();
                if (c + 1 == 2) begin
                    sgn = 1'b1;
                    dividend = 32'd9;
                    divisor = 32'd0;
                end
                start = (c + 1 >= 5) && (c + 1 <= 8);
            end
            chk("ignored start latency", 64'(lat), 64'd33);
            chk("ignored start result", res, {32'd2, 32'd14});
        end

        // Asynchronous reset at cycle 20 of a run
        begin
            sgn = 1'b0;
            dividend = 32'd100;
            divisor = 32'd7;
            start = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                tick();
                start = 1'b0;
            end
            #2;
            rst_n = 1'b0;
            #1;
            chk("async reset result", result, 64'h0);
            chk("async reset ready", {63'd0, ready}, 64'd0);
            chk("async reset busy", {63'd0, busy}, 64'd0);
            tick();
            chk("held reset busy", {63'd0, busy}, 64'd0);
            rst_n = 1'b1;
            tick();
        end
        run_check("after reset", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
